// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-lite encodings and slave state type for the miniTB memory responder.
package minitb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/minitb_sp_ram.sv
// Word array with one synchronous write port and one combinational read port.
module minitb_sp_ram #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32,
    parameter int DEPTH     = 2**addrWidth
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [addrWidth-1:0] i_waddr,
    input  logic [dataWidth-1:0] i_wdata,
    input  logic [addrWidth-1:0] i_raddr,
    output logic [dataWidth-1:0] o_rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [dataWidth-1:0] r_mem [DEPTH];

    // Callers only present in-range addresses, so the low bits index directly.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr[IW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr[IW-1:0]];

endmodule

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-lite word memory slave: read data registered at the accepting edge, WAIT_STATES
// hready-low cycles per OKAY data phase, two-cycle ERROR for addresses >= DEPTH.
module minitb_ahb_slave_mem
    import minitb_ahb_pkg::*;
#(
    parameter int addrWidth   = 8,
    parameter int dataWidth   = 32,
    parameter int DEPTH       = 2**addrWidth,
    parameter int WAIT_STATES = 0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [dataWidth-1:0] hwdata,
    output logic                 hready,
    output logic [1:0]           hresp,
    output logic [dataWidth-1:0] hrdata
);

    localparam logic [addrWidth:0]    LP_DEPTH = (addrWidth+1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] LP_WS    = WAIT_CNT_W'(WAIT_STATES);

    slave_state_t          r_state;
    logic                  r_hready;
    logic [1:0]            r_hresp;
    logic [dataWidth-1:0]  r_hrdata;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [addrWidth-1:0]  r_addr;
    logic                  r_write;
    logic                  r_dp_vld;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic                  w_fwd;
    logic [dataWidth-1:0]  w_ram_rdata;

    assign w_accept   = r_hready && hsel && is_active(htrans);
    assign w_in_range = ({1'b0, haddr} < LP_DEPTH);
    assign w_wr_en    = r_hready && r_dp_vld && r_write;
    // A read landing on the edge that retires a write to the same word must see hwdata.
    assign w_fwd      = w_wr_en && (r_addr == haddr);

    minitb_sp_ram #(
        .addrWidth (addrWidth),
        .dataWidth (dataWidth),
        .DEPTH     (DEPTH)
    ) u_ram (
        .i_clk   (hclk),
        .i_we    (w_wr_en),
        .i_waddr (r_addr),
        .i_wdata (hwdata),
        .i_raddr (haddr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
            r_hrdata <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_dp_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_OKAY;
                    r_dp_vld <= 1'b0;
                    if (w_accept) begin
                        r_addr  <= haddr;
                        r_write <= hwrite;
                        if (!hwrite) begin
                            r_hrdata <= !w_in_range ? '0 :
                                        (w_fwd ? hwdata : w_ram_rdata);
                        end
                        if (!w_in_range) begin
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= HRESP_ERROR;
                        end else begin
                            r_dp_vld <= 1'b1;
                            if (LP_WS != '0) begin
                                r_state  <= ST_WAIT;
                                r_cnt    <= LP_WS;
                                r_hready <= 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == WAIT_CNT_W'(1)) begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_OKAY;
                    r_dp_vld <= 1'b0;
                end
            endcase
        end
    end

    assign hready = r_hready;
    assign hresp  = r_hresp;
    assign hrdata = r_hrdata;

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Directed bench: three slave variants (no waits, 2 wait states, 16-word depth) share one bus.
module tb_minitb_ahb_slave_mem;
    import minitb_ahb_pkg::*;

    logic        hclk;
    logic        hreset;
    logic        hsel;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [31:0] hwdata;

    logic        hready_a, hready_b, hready_c;
    logic [1:0]  hresp_a, hresp_b, hresp_c;
    logic [31:0] hrdata_a, hrdata_b, hrdata_c;

    int n_assert;
    int n_fail;

    minitb_ahb_slave_mem u_dut_a (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hready_a), .hresp(hresp_a), .hrdata(hrdata_a)
    );

    minitb_ahb_slave_mem #(.WAIT_STATES(2)) u_dut_b (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hready_b), .hresp(hresp_b), .hrdata(hrdata_b)
    );

    minitb_ahb_slave_mem #(.DEPTH(16)) u_dut_c (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hready_c), .hresp(hresp_c), .hrdata(hrdata_c)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hreset = 1'b1;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        hreset = 1'b1;
        hsel   = 1'b1;
        htrans = HTRANS_IDLE;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = '0;

        // Reset, then idle bus
        @(negedge hclk);
        chk("rst_hready", 32'(hready_a), 32'd1);
        chk("rst_hresp", 32'(hresp_a), 32'd0);
        chk("rst_hrdata", hrdata_a, 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk);
            chk("idle_hready", 32'(hready_a), 32'd1);
            chk("idle_hresp", 32'(hresp_a), 32'd0);
            chk("idle_hrdata", hrdata_a, 32'd0);
        end

        // Write then read, no wait states
        htrans = HTRANS_NONSEQ; haddr = 8'h10; hwrite = 1'b1;
        @(negedge hclk);
        chk("t2_wr_hready", 32'(hready_a), 32'd1);
        hwdata = 32'hDEADBEEF; htrans = HTRANS_IDLE; hwrite = 1'b0;
        @(negedge hclk);
        chk("t2_dp_hready", 32'(hready_a), 32'd1);
        htrans = HTRANS_NONSEQ; haddr = 8'h10; hwrite = 1'b0;
        @(negedge hclk);
        chk("t2_rd_hready", 32'(hready_a), 32'd1);
        chk("t2_rd_hresp", 32'(hresp_a), 32'd0);
        chk("t2_rd_data", hrdata_a, 32'hDEADBEEF);
        htrans = HTRANS_IDLE;

        // Read-after-write forwarding
        @(negedge hclk);
        htrans = HTRANS_NONSEQ; haddr = 8'h20; hwrite = 1'b1;
        @(negedge hclk);
        hwdata = 32'h11111111; htrans = HTRANS_IDLE; hwrite = 1'b0;
        @(negedge hclk);
        htrans = HTRANS_NONSEQ; haddr = 8'h20; hwrite = 1'b1;
        @(negedge hclk);
        hwdata = 32'h12345678; htrans = HTRANS_NONSEQ; haddr = 8'h20; hwrite = 1'b0;
        @(negedge hclk);
        chk("t3_fwd_hready", 32'(hready_a), 32'd1);
        chk("t3_fwd_data", hrdata_a, 32'h12345678);
        htrans = HTRANS_IDLE;

        // Wait states (instance b, WAIT_STATES=2)
        do_reset();
        htrans = HTRANS_NONSEQ; haddr = 8'h05; hwrite = 1'b1;
        @(negedge hclk);
        chk("t4_wr_wait1", 32'(hready_b), 32'd0);
        hwdata = 32'hA5A5A5A5; htrans = HTRANS_IDLE; hwrite = 1'b0;
        @(negedge hclk);
        chk("t4_wr_wait2", 32'(hready_b), 32'd0);
        @(negedge hclk);
        chk("t4_wr_done", 32'(hready_b), 32'd1);
        chk("t4_wr_hresp", 32'(hresp_b), 32'd0);
        @(negedge hclk);
        chk("t4_idle_hready", 32'(hready_b), 32'd1);
        htrans = HTRANS_NONSEQ; haddr = 8'h05; hwrite = 1'b0;
        @(negedge hclk);
        chk("t4_rd_wait1", 32'(hready_b), 32'd0);
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        chk("t4_rd_wait2", 32'(hready_b), 32'd0);
        @(negedge hclk);
        chk("t4_rd_done", 32'(hready_b), 32'd1);
        chk("t4_rd_data", hrdata_b, 32'hA5A5A5A5);

        // Out-of-range (instance c, DEPTH=16)
        do_reset();
        htrans = HTRANS_NONSEQ; haddr = 8'h00; hwrite = 1'b1;
        @(negedge hclk);
        hwdata = 32'hCAFEF00D; htrans = HTRANS_IDLE; hwrite = 1'b0;
        @(negedge hclk);
        chk("t5_pre_hready", 32'(hready_c), 32'd1);
        chk("t5_pre_hresp", 32'(hresp_c), 32'd0);
        htrans = HTRANS_NONSEQ; haddr = 8'h20; hwrite = 1'b1;
        @(negedge hclk);
        chk("t5_err1_hready", 32'(hready_c), 32'd0);
        chk("t5_err1_hresp", 32'(hresp_c), 32'd1);
        hwdata = 32'h00000001; htrans = HTRANS_IDLE; hwrite = 1'b0;
        @(negedge hclk);
        chk("t5_err2_hready", 32'(hready_c), 32'd1);
        chk("t5_err2_hresp", 32'(hresp_c), 32'd1);
        htrans = HTRANS_NONSEQ; haddr = 8'h00; hwrite = 1'b0;
        @(negedge hclk);
        chk("t5_rd_hready", 32'(hready_c), 32'd1);
        chk("t5_rd_hresp", 32'(hresp_c), 32'd0);
        chk("t5_rd_data", hrdata_c, 32'hCAFEF00D);
        htrans = HTRANS_NONSEQ; haddr = 8'h20; hwrite = 1'b0;
        @(negedge hclk);
        chk("t5_oor_rd_hready", 32'(hready_c), 32'd0);
        chk("t5_oor_rd_hresp", 32'(hresp_c), 32'd1);
        chk("t5_oor_rd_data", hrdata_c, 32'd0);
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        chk("t5_oor_err2_hready", 32'(hready_c), 32'd1);
        chk("t5_oor_err2_hresp", 32'(hresp_c), 32'd1);
        @(negedge hclk);
        chk("t5_back_hresp", 32'(hresp_c), 32'd0);

        // Reset in the middle of a write data phase
        do_reset();
        htrans = HTRANS_NONSEQ; haddr = 8'h30; hwrite = 1'b1;
        @(negedge hclk);
        hwdata = 32'h00000000; htrans = HTRANS_IDLE; hwrite = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        chk("t6_pre_done", 32'(hready_b), 32'd1);
        @(negedge hclk);
        htrans = HTRANS_NONSEQ; haddr = 8'h30; hwrite = 1'b1;
        @(negedge hclk);
        chk("t6_dp_hready", 32'(hready_b), 32'd0);
        hwdata = 32'hFFFF0000; htrans = HTRANS_IDLE; hwrite = 1'b0;
        #2 hreset = 1'b1;
        #1;
        chk("t6_rst_hready_b", 32'(hready_b), 32'd1);
        chk("t6_rst_hresp_b", 32'(hresp_b), 32'd0);
        chk("t6_rst_hready_a", 32'(hready_a), 32'd1);
        @(negedge hclk);
        hreset = 1'b0;
        htrans = HTRANS_NONSEQ; haddr = 8'h30; hwrite = 1'b0;
        @(negedge hclk);
        chk("t6_rd_hready_a", 32'(hready_a), 32'd1);
        chk("t6_rd_data_a", hrdata_a, 32'h00000000);
        chk("t6_rd_wait_b", 32'(hready_b), 32'd0);
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        @(negedge hclk);
        chk("t6_rd_hready_b", 32'(hready_b), 32'd1);
        chk("t6_rd_data_b", hrdata_b, 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
